// File: rtl/data_mem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// data_mem_responder : word-wide data RAM with programmable completion latency
//                      serving the multicycle core's data port
// Rev 1.0
// ============================================================================
module data_mem_responder #(
  parameter logic [31:0] DATA_BASE   = 32'h1001_0000,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2,
  parameter logic [31:0] ERR_DATA    = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dAddress,
  input  logic [31:0] dWriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] dReadData,
  output logic        dValid,
  output logic        dBusy,
  output logic        dError
);

  localparam int unsigned c_aw      = $clog2(DEPTH_WORDS);
  localparam logic [29:0] c_base_w  = DATA_BASE[31:2];
  localparam logic [3:0]  c_lat_m1  = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_req_q;
  logic [3:0]        r_cnt;
  logic              r_rd;
  logic              r_wr;
  logic              r_fault;
  logic [c_aw-1:0]   r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_req;
  logic              w_accept;
  logic              w_complete;
  logic [29:0]       w_word_off;
  logic              w_fault;

  assign w_req      = MemRead | MemWrite;
  assign w_accept   = w_req & ~r_req_q & (r_state == ST_IDLE);
  assign w_complete = (r_state == ST_WAIT) && (r_cnt == 4'd0);

  // Offset wraps for addresses below the base; the explicit compare catches those.
  assign w_word_off = dAddress[31:2] - c_base_w;
  assign w_fault    = (dAddress[1:0] != 2'b00)
                    | (dAddress < DATA_BASE)
                    | (w_word_off[29:c_aw] != '0)
                    | (MemRead & MemWrite);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    dValid = 1'b0;
    dBusy  = 1'b0;
    dError = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        dBusy = 1'b1;
        if (r_cnt == 4'd0) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        dValid = 1'b1;
        dError = r_fault;
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  // Request capture, latency counter and read-data register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_req_q   <= 1'b0;
      r_cnt     <= 4'd0;
      r_rd      <= 1'b0;
      r_wr      <= 1'b0;
      r_fault   <= 1'b0;
      r_idx     <= '0;
      r_wdata   <= 32'd0;
      dReadData <= 32'd0;
    end else begin
      r_req_q <= w_req;
      if (w_accept) begin
        r_cnt   <= c_lat_m1;
        r_rd    <= MemRead;
        r_wr    <= MemWrite;
        r_fault <= w_fault;
        r_idx   <= w_word_off[c_aw-1:0];
        r_wdata <= dWriteData;
      end else if ((r_state == ST_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_complete && r_rd) begin
        dReadData <= r_fault ? ERR_DATA : r_mem[r_idx];
      end
    end
  end

  // Storage is never reset; a reset before completion leaves it untouched.
  always_ff @(posedge clk) begin
    if (w_complete && r_wr && !r_fault) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

endmodule
`default_nettype wire
